// File: rtl/psum_accum_16.sv
// rtl/psum_accum_16.sv - partial-sum accumulator with a 16-entry scratchpad and a 2-entry result FIFO
// The scratchpad read is combinational so back-to-back beats to one entry see the updated value.
module psum_accum_16 #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              prod_valid,
   output logic              prod_ready,
   input  logic [DATA_W-1:0] prod,
   input  logic [ADDR_W-1:0] prod_addr,
   input  logic              prod_first,
   input  logic              prod_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic [15:0]       done_count
);

   logic [DATA_W-1:0] r_spad [DEPTH];
   logic [DATA_W-1:0] r_fifo_data [2];
   logic [ADDR_W-1:0] r_fifo_addr [2];
   logic              r_wr_ptr;
   logic              r_rd_ptr;
   logic [1:0]        r_count;
   logic [15:0]       r_done_count;

   logic              w_xfer;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_sum;

   // Readiness depends only on registered occupancy, never on prod_valid.
   assign prod_ready = (r_count < 2'd2);
   assign w_xfer     = prod_valid && prod_ready;
   assign w_push     = w_xfer && prod_last;
   assign out_valid  = (r_count != 2'd0);
   assign w_pop      = out_valid && out_ready;
   assign w_sum      = prod_first ? prod : (r_spad[prod_addr] + prod);

   assign out_data   = r_fifo_data[r_rd_ptr];
   assign out_addr   = r_fifo_addr[r_rd_ptr];
   assign done_count = r_done_count;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_spad[i] <= '0;
         end
      end else if (w_xfer) begin
         r_spad[prod_addr] <= w_sum;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_fifo_data[0] <= '0;
         r_fifo_data[1] <= '0;
         r_fifo_addr[0] <= '0;
         r_fifo_addr[1] <= '0;
         r_wr_ptr       <= 1'b0;
         r_rd_ptr       <= 1'b0;
         r_count        <= 2'd0;
         r_done_count   <= 16'd0;
      end else begin
         if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_sum;
            r_fifo_addr[r_wr_ptr] <= prod_addr;
            r_wr_ptr              <= ~r_wr_ptr;
            r_done_count          <= r_done_count + 16'd1;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_psum_accum_16.sv
// tb/tb_psum_accum_16.sv - vector table, reset corner case and randomized model comparison for psum_accum_16
module tb_psum_accum_16;

   logic        CLK;
   logic        RST;
   logic        prod_valid;
   logic        prod_ready;
   logic [15:0] prod;
   logic [3:0]  prod_addr;
   logic        prod_first;
   logic        prod_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_addr;
   logic [15:0] done_count;

   int n_pass  = 0;
   int n_total = 0;

   psum_accum_16 dut (
      .CLK        (CLK),
      .RST        (RST),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod       (prod),
      .prod_addr  (prod_addr),
      .prod_first (prod_first),
      .prod_last  (prod_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_addr   (out_addr),
      .done_count (done_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        v;
      logic [3:0]  a;
      logic [15:0] p;
      logic        f;
      logic        l;
      logic        ordy;
      logic        ev;
      logic [15:0] ed;
      logic [3:0]  ea;
      logic [15:0] edone;
      logic        erdy;
   } vec_t;

   typedef struct {
      logic [3:0]  a;
      logic [15:0] d;
   } ent_t;

   vec_t        tbl[$];
   logic [15:0] m_spad [16];
   ent_t        m_q[$];
   logic [15:0] m_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] a, input logic [15:0] p,
                               input logic f, input logic l, input logic ordy,
                               input logic ev, input logic [15:0] ed, input logic [3:0] ea,
                               input logic [15:0] edone, input logic erdy);
      vec_t r;
      r.v = v; r.a = a; r.p = p; r.f = f; r.l = l; r.ordy = ordy;
      r.ev = ev; r.ed = ed; r.ea = ea; r.edone = edone; r.erdy = erdy;
      return r;
   endfunction

   task automatic drive(input logic v, input logic [3:0] a, input logic [15:0] p,
                        input logic f, input logic l, input logic ordy);
      prod_valid = v; prod_addr = a; prod = p; prod_first = f; prod_last = l; out_ready = ordy;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1;
      drive(1'b0, 4'd0, 16'd0, 1'b0, 1'b0, 1'b0);

      // columns: v addr prod first last out_ready | out_valid out_data out_addr done_count prod_ready
      tbl.push_back(mk(1, 4'd3, 16'd5,      1, 0, 1,  0, 16'd0,  4'd0, 16'd0,  1));
      tbl.push_back(mk(1, 4'd3, 16'd7,      0, 1, 0,  1, 16'd12, 4'd3, 16'd1,  1));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  0, 16'd0,  4'd0, 16'd1,  1));
      tbl.push_back(mk(1, 4'd0, 16'hFFFF,   1, 0, 1,  0, 16'd0,  4'd0, 16'd1,  1));
      tbl.push_back(mk(1, 4'd0, 16'h0002,   0, 1, 0,  1, 16'd1,  4'd0, 16'd2,  1));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  0, 16'd0,  4'd0, 16'd2,  1));
      tbl.push_back(mk(1, 4'd0, 16'hFFFE,   1, 0, 1,  0, 16'd0,  4'd0, 16'd2,  1));
      tbl.push_back(mk(1, 4'd0, 16'h0005,   0, 1, 0,  1, 16'd3,  4'd0, 16'd3,  1));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  0, 16'd0,  4'd0, 16'd3,  1));
      tbl.push_back(mk(1, 4'd1, 16'd1,      1, 1, 0,  1, 16'd1,  4'd1, 16'd4,  1));
      tbl.push_back(mk(1, 4'd2, 16'd2,      1, 1, 0,  1, 16'd1,  4'd1, 16'd5,  0));
      tbl.push_back(mk(1, 4'd3, 16'd3,      1, 1, 0,  1, 16'd1,  4'd1, 16'd5,  0));
      tbl.push_back(mk(1, 4'd3, 16'd3,      1, 1, 1,  1, 16'd2,  4'd2, 16'd5,  1));
      tbl.push_back(mk(1, 4'd3, 16'd3,      1, 1, 1,  1, 16'd3,  4'd3, 16'd6,  1));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  0, 16'd0,  4'd0, 16'd6,  1));
      tbl.push_back(mk(1, 4'd5, 16'd9,      1, 1, 0,  1, 16'd9,  4'd5, 16'd7,  1));
      tbl.push_back(mk(1, 4'd7, 16'd11,     1, 1, 1,  1, 16'd11, 4'd7, 16'd8,  1));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  0, 16'd0,  4'd0, 16'd8,  1));
      tbl.push_back(mk(1, 4'd4, 16'd2,      1, 0, 1,  0, 16'd0,  4'd0, 16'd8,  1));
      tbl.push_back(mk(1, 4'd9, 16'd10,     1, 0, 1,  0, 16'd0,  4'd0, 16'd8,  1));
      tbl.push_back(mk(1, 4'd4, 16'd3,      0, 1, 0,  1, 16'd5,  4'd4, 16'd9,  1));
      tbl.push_back(mk(1, 4'd9, 16'd20,     0, 1, 0,  1, 16'd5,  4'd4, 16'd10, 0));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  1, 16'd30, 4'd9, 16'd10, 1));
      tbl.push_back(mk(0, 4'd0, 16'd0,      0, 0, 1,  0, 16'd0,  4'd0, 16'd10, 1));
      tbl.push_back(mk(0, 4'd3, 16'd99,     1, 1, 1,  0, 16'd0,  4'd0, 16'd10, 1));

      #12;
      check("reset out_valid", {31'd0, out_valid}, 32'd0);
      check("reset out_data", {16'd0, out_data}, 32'd0);
      check("reset out_addr", {28'd0, out_addr}, 32'd0);
      check("reset done_count", {16'd0, done_count}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      #1;
      check("reset prod_ready", {31'd0, prod_ready}, 32'd1);

      foreach (tbl[i]) begin
         drive(tbl[i].v, tbl[i].a, tbl[i].p, tbl[i].f, tbl[i].l, tbl[i].ordy);
         step();
         check($sformatf("row%0d out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
         if (tbl[i].ev) begin
            check($sformatf("row%0d out_data", i), {16'd0, out_data}, {16'd0, tbl[i].ed});
            check($sformatf("row%0d out_addr", i), {28'd0, out_addr}, {28'd0, tbl[i].ea});
         end
         check($sformatf("row%0d done_count", i), {16'd0, done_count}, {16'd0, tbl[i].edone});
         check($sformatf("row%0d prod_ready", i), {31'd0, prod_ready}, {31'd0, tbl[i].erdy});
      end

      // Reset mid-window: entry 6 holds 40, one result waiting in the FIFO.
      drive(1, 4'd6, 16'd25, 1, 0, 0); step();
      drive(1, 4'd6, 16'd15, 0, 0, 0); step();
      drive(1, 4'd2, 16'd8,  1, 1, 0); step();
      check("midrst pre out_valid", {31'd0, out_valid}, 32'd1);
      drive(0, 4'd0, 16'd0, 0, 0, 0);
      #3;
      RST = 1'b1;
      #1;
      check("midrst out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst out_data", {16'd0, out_data}, 32'd0);
      check("midrst out_addr", {28'd0, out_addr}, 32'd0);
      check("midrst done_count", {16'd0, done_count}, 32'd0);
      #1;
      RST = 1'b0;
      #1;
      check("midrst prod_ready", {31'd0, prod_ready}, 32'd1);
      drive(1, 4'd6, 16'd1, 0, 1, 0); step();
      check("postrst out_valid", {31'd0, out_valid}, 32'd1);
      check("postrst out_data", {16'd0, out_data}, 32'd1);
      check("postrst out_addr", {28'd0, out_addr}, 32'd6);
      check("postrst done_count", {16'd0, done_count}, 32'd1);

      drive(0, 4'd0, 16'd0, 0, 0, 0);
      RST = 1'b1;
      #1;
      RST = 1'b0;
      for (int k = 0; k < 16; k++) m_spad[k] = 16'd0;
      m_q.delete();
      m_done = 16'd0;

      for (int c = 0; c < 3000; c++) begin
         logic v, f, l, ordy, m_ready, m_xfer;
         logic [3:0]  a;
         logic [15:0] p, s;
         ent_t e;
         v    = ($urandom_range(0, 9) < 7);
         f    = ($urandom_range(0, 3) == 0);
         l    = ($urandom_range(0, 9) < 3);
         ordy = ($urandom_range(0, 9) < 6);
         a    = 4'($urandom_range(0, 15));
         p    = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
         drive(v, a, p, f, l, ordy);
         m_ready = (m_q.size() < 2);
         check("rand prod_ready", {31'd0, prod_ready}, {31'd0, m_ready});
         m_xfer = v && m_ready;
         if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
         if (m_xfer) begin
            s = f ? p : 16'(m_spad[a] + p);
            m_spad[a] = s;
            if (l) begin
               e.a = a;
               e.d = s;
               m_q.push_back(e);
               m_done = m_done + 16'd1;
            end
         end
         step();
         check("rand out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() > 0)});
         if (m_q.size() > 0) begin
            check("rand out_data", {16'd0, out_data}, {16'd0, m_q[0].d});
            check("rand out_addr", {28'd0, out_addr}, {28'd0, m_q[0].a});
         end
         check("rand done_count", {16'd0, done_count}, {16'd0, m_done});
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/psum_accum_16.md
Name: psum_accum_16

Overview:
- Partial-sum accumulation stage directly downstream of the 16-bit fixed-point multiplier in the PE.
- Consumes the registered, already-rescaled 16-bit product and accumulates it into a local psum scratchpad entry, modulo 2^16.
- On the last product of a window, emits the finished psum through a 2-entry output FIFO with valid/ready handshake toward the PE's psum output.
- Backpressures the multiplier path when the FIFO is full.

Parameters:
- DATA_W, 16, width of product, psum entries and output data.
- DEPTH, 16, number of psum scratchpad entries.
- ADDR_W, 4, scratchpad address width (log2 DEPTH).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- prod_valid  in  1  product beat present this cycle; aligned with prod (sender compensates for the multiplier's 1-cycle register).
- prod_ready  out  1  stage accepts a beat; beat transfers when prod_valid && prod_ready.
- prod  in  DATA_W  multiplier output, already shifted by the multiplier's bits setting.
- prod_addr  in  ADDR_W  psum entry to accumulate into.
- prod_first  in  1  start new window: entry loaded with prod instead of entry+prod.
- prod_last  in  1  close window: resulting sum also pushed to output FIFO.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head; pop when out_valid && out_ready.
- out_data  out  DATA_W  finished psum at FIFO head.
- out_addr  out  ADDR_W  entry index that produced out_data.
- done_count  out  16  number of psums pushed since reset; wraps at 2^16.

Behaviour:
- Reset (async, any cycle, including mid-window): all DEPTH entries <= 0; FIFO emptied (pointers 0, count 0); out_valid = 0, out_data = 0, out_addr = 0; done_count = 0; prod_ready = 1 as soon as RST deasserts. In-flight windows are lost, not resumed.
- Accept condition: xfer = prod_valid && prod_ready.
- prod_ready = (fifo_count < 2). This is combinational from registered state only; it never depends on prod_valid.
- Sum: sum = prod_first ? prod : spad[prod_addr] + prod.
  - Scratchpad read is combinational.
  - Addition is unsigned DATA_W-bit with wrap: carry discarded, no saturation. This is bit-identical to two's-complement signed wrap.
- On xfer: spad[prod_addr] <= sum at the clock edge. Back-to-back beats to the same address therefore see the updated value; there is no hazard and no bubble. Latency is 1 cycle from beat to entry update.
- On xfer with prod_last: push {prod_addr, sum} into the FIFO in the same edge and increment done_count. If prod_first and prod_last are both set, the result equals prod.
- On a cycle with no xfer, the scratchpad holds its contents.
- FIFO is 2 entries. It is the block's only buffering.
  - Push and pop in the same cycle is allowed at any count: count unchanged, pointers both advance.
  - Push while full cannot occur, because prod_ready = 0 in that case.
  - Pop while empty is ignored.
- Output timing: out_valid/out_data/out_addr are registered FIFO-head outputs.
  - A pushed result is visible the cycle after the push edge, so beat-to-out_valid latency is 1 cycle.
  - out_data/out_addr hold stable while out_valid && !out_ready.
- Beats with prod_valid = 0 ignore prod_first/prod_last.

Test Plan:
- After reset: beat {addr 3, prod 5, first} then beat {addr 3, prod 7, last} on consecutive cycles -> next cycle out_valid = 1, out_data = 12, out_addr = 3, done_count = 1.
- Wrap: beat {addr 0, 0xFFFF, first}, then {addr 0, 0x0002, last} -> out_data = 0x0001. Signed check: {0xFFFE (-2), first} + {0x0005, last} -> 0x0003.
- Backpressure: out_ready = 0, three consecutive single-beat windows {first, last}, values 1, 2, 3 at addrs 1, 2, 3 -> prod_ready falls to 0 after the second push. The third beat is held with no loss. Raise out_ready -> outputs 1, 2, 3 in order, and prod_ready returns to 1 the cycle after the first pop.
- Simultaneous push/pop: FIFO holds 1 entry, out_ready = 1, last-beat arrives -> count stays 1, ordering preserved, no bubble on out_valid.
- Interleaved entries: windows on addr 4 (2 + 3) and addr 9 (10 + 20) interleaved beat-by-beat -> outputs {4, 5} and {9, 30} in last-beat order.
- Reset mid-window: addr 6 accumulated to 40 (no last), FIFO holding 1 entry, assert RST asynchronously between edges -> outputs and done_count 0 immediately. After release, beat {addr 6, prod 1, last} without first -> out_data = 1.
